// File: rtl/data_mem_responder.sv
// Handshaked multi-cycle data memory: slave end of the core's load/store port.
// Optional: define DMEM_MISALIGN_CHECK_EN to flag misaligned half/word accesses on rsp_err.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned XW = AW + 2;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_we;
  logic [1:0]      r_size;
  logic [XW-1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic            r_req_ready;
  logic            r_rsp_valid;
  logic [31:0]     r_rsp_rdata;
  logic            r_rsp_err;
  logic [31:0]     r_mem [DEPTH];

  state_t          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_accept;
  logic            w_sel_we;
  logic [1:0]      w_sel_size;
  logic [XW-1:0]   w_sel_addr;
  logic [31:0]     w_sel_wdata;
  logic            w_word;
  logic            w_half;
  logic [1:0]      w_off;
  logic            w_err;
  logic [AW-1:0]   w_idx;
  logic [4:0]      w_shamt;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata_sh;
  logic [31:0]     w_rdata_ld;
  logic            w_commit;
  logic            w_rsp_valid_nxt;
  logic [31:0]     w_rsp_rdata_nxt;
  logic            w_rsp_err_nxt;
  logic            w_req_ready_nxt;
  logic            w_unused_addr;

  assign w_unused_addr = ^req_addr[31:XW];

  // Next-state and acceptance
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_req_ready && req_valid) begin
          w_accept = 1'b1;
          if (LATENCY <= 1) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Access decode; on acceptance the live request is used so LATENCY=1 can respond next cycle
  always_comb begin
    w_sel_we    = w_accept ? req_we            : r_we;
    w_sel_size  = w_accept ? req_size          : r_size;
    w_sel_addr  = w_accept ? req_addr[XW-1:0]  : r_addr;
    w_sel_wdata = w_accept ? req_wdata         : r_wdata;
    w_word      = w_sel_size[1];
    w_half      = (w_sel_size == 2'b01);
`ifdef DMEM_MISALIGN_CHECK_EN
    w_off = w_sel_addr[1:0];
    w_err = (w_half && w_sel_addr[0]) || (w_word && (w_sel_addr[1:0] != 2'b00));
`else
    w_off = w_word ? 2'b00 : (w_half ? {w_sel_addr[1], 1'b0} : w_sel_addr[1:0]);
    w_err = 1'b0;
`endif
    w_idx      = w_sel_addr[XW-1:2];
    w_shamt    = {w_off, 3'b000};
    w_be       = w_word ? 4'b1111 : (w_half ? (4'b0011 << w_off) : (4'b0001 << w_off));
    w_wdata_sh = w_sel_wdata << w_shamt;
    w_rdata_ld = r_mem[w_idx] >> w_shamt;
  end

  // Registered response values, loaded on the edge that enters RESP
  always_comb begin
    w_rsp_valid_nxt = (w_state_nxt == S_RESP);
    w_rsp_err_nxt   = w_rsp_valid_nxt && w_err;
    w_rsp_rdata_nxt = '0;
    if (w_rsp_valid_nxt && !w_sel_we && !w_err) begin
      w_rsp_rdata_nxt = w_rdata_ld;
    end
    w_req_ready_nxt = (w_state_nxt == S_IDLE);
    w_commit        = (r_state == S_RESP) && r_we && !w_err;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      if (w_accept) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_addr  <= req_addr[XW-1:0];
        r_wdata <= req_wdata;
      end
    end
  end

  // Store commit at the end of RESP; reset in the same cycle discards it
  always_ff @(posedge clk) begin
    if (rst && w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
